braille_uart_tx: RTL and testbench

BRAILLE_UART_TX -- requirements
Module: braille_uart_tx

---
 rtl/braille_uart_tx_pkg.sv | 29 ++
 rtl/braille_uart_tx_result_fifo.sv | 48 ++++
 rtl/braille_uart_tx.sv | 159 +++++++++++++++
 tb/tb_braille_uart_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/braille_uart_tx_pkg.sv
// Shared constants for the braille UART transmitter: packet framing, FSM
// encoding and the 6-dot braille cell table for 'a'..'z'.
package braille_uart_tx_pkg;

    localparam logic [7:0] PKT_HDR = 8'hAA;
    localparam int         PKT_LEN = 4;
    localparam logic [7:0] ALPHA_LO = 8'h61;
    localparam logic [7:0] ALPHA_HI = 8'h7A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // Bit0 = dot1 .. bit5 = dot6, indexed by (alpha - 'a').
    localparam logic [7:0] DOT_TBL [26] = '{
        8'h01, 8'h03, 8'h09, 8'h19, 8'h11, 8'h0B, 8'h1B, 8'h13, 8'h0A,
        8'h1A, 8'h05, 8'h07, 8'h0D, 8'h1D, 8'h15, 8'h0F, 8'h1F, 8'h17,
        8'h0E, 8'h1E, 8'h25, 8'h27, 8'h3A, 8'h2D, 8'h3D, 8'h35
    };

    function automatic logic is_alpha(input logic [7:0] a);
        return (a >= ALPHA_LO) && (a <= ALPHA_HI);
    endfunction

endpackage

// File: rtl/braille_uart_tx_result_fifo.sv
// Result FIFO between the classifier strobe and the packet serializer.
// Supports simultaneous push and pop, including when full.
module result_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic [W-1:0]  mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/braille_uart_tx.sv
// Buffers classified characters and sends each as a 4-byte packet
// (header, alpha, braille dots, checksum) over an 8N1 UART line.
module braille_uart_tx
    import braille_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_valid,
    input  logic [7:0] i_alpha,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_overflow,
    output logic       o_bad_char
);

    state_e                        state_q, state_d;
    logic [15:0]                   baud_q, baud_d;
    logic [2:0]                    bit_q, bit_d;
    logic [1:0]                    byte_q, byte_d;
    logic [PKT_LEN-1:0][7:0]       pkt_q, pkt_d;
    logic                          tx_q, tx_d;
    logic                          busy_q, busy_d;
    logic                          ovf_q, ovf_d;
    logic                          bad_q, bad_d;

    logic       fifo_full, fifo_empty, pop, push_ok;
    logic [7:0] fifo_rd, ld_dots;
    logic [4:0] ld_idx;
    logic [2:0] nbit;
    logic       baud_last;

    assign pop     = (state_q == S_LOAD);
    assign push_ok = i_valid && (!fifo_full || pop);

    result_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (push_ok),
        .din_i   (i_alpha),
        .pop_i   (pop),
        .dout_o  (fifo_rd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        ld_idx  = 5'(fifo_rd - ALPHA_LO);
        ld_dots = is_alpha(fifo_rd) ? DOT_TBL[ld_idx] : 8'h00;
    end

    assign baud_last = (baud_q == 16'(CLKS_PER_BIT - 1));
    assign nbit      = bit_q + 3'd1;

    // tx_d is the line level for the next cycle, so o_tx is a plain flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        pkt_d   = pkt_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                pkt_d   = {PKT_HDR ^ fifo_rd ^ ld_dots, ld_dots, fifo_rd, PKT_HDR};
                byte_d  = '0;
                bit_d   = '0;
                baud_d  = '0;
                tx_d    = 1'b0;
                state_d = S_START;
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = pkt_q[byte_q][0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d = nbit;
                        tx_d  = pkt_q[byte_q][nbit];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (byte_q != 2'(PKT_LEN - 1)) begin
                        byte_d  = byte_q + 2'd1;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        byte_d  = '0;
                        tx_d    = 1'b1;
                        state_d = fifo_empty ? S_IDLE : S_LOAD;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        // A pop only happens in LOAD, which always leaves state_d busy.
        busy_d = (state_d != S_IDLE) || push_ok || !fifo_empty;
        ovf_d  = ovf_q || (i_valid && fifo_full && !pop);
        bad_d  = bad_q || (push_ok && !is_alpha(i_alpha));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            pkt_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            pkt_q   <= pkt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            bad_q   <= bad_d;
        end
    end

    assign o_tx       = tx_q;
    assign o_busy     = busy_q;
    assign o_overflow = ovf_q;
    assign o_bad_char = bad_q;

endmodule

// File: tb/tb_braille_uart_tx.sv
// Scoreboard bench: expected packet bytes are queued at each push and
// compared against bytes decoded from o_tx by a UART receiver process.
module tb_braille_uart_tx;

    localparam int CPB = 4;
    localparam logic [7:0] TB_DOTS [26] = '{
        8'h01, 8'h03, 8'h09, 8'h19, 8'h11, 8'h0B, 8'h1B, 8'h13, 8'h0A,
        8'h1A, 8'h05, 8'h07, 8'h0D, 8'h1D, 8'h15, 8'h0F, 8'h1F, 8'h17,
        8'h0E, 8'h1E, 8'h25, 8'h27, 8'h3A, 8'h2D, 8'h3D, 8'h35
    };

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_valid;
    logic [7:0] i_alpha;
    logic       o_tx, o_busy, o_overflow, o_bad_char;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         pcyc = 0;
    logic [7:0] exp_q [$];

    braille_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_valid    (i_valid),
        .i_alpha    (i_alpha),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_overflow (o_overflow),
        .o_bad_char (o_bad_char)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic exp_push(input logic [7:0] a);
        logic [7:0] d;
        int idx;
        idx = int'(a) - 'h61;
        d = (idx >= 0 && idx < 26) ? TB_DOTS[idx] : 8'h00;
        exp_q.push_back(8'hAA);
        exp_q.push_back(a);
        exp_q.push_back(d);
        exp_q.push_back(8'hAA ^ a ^ d);
    endtask

    // Raises i_valid for the next edge; caller drops it when done.
    task automatic push(input logic [7:0] a, input bit acc);
        @(negedge clk);
        i_valid = 1'b1;
        i_alpha = a;
        pcyc    = cyc + 1;
        if (acc) exp_push(a);
    endtask

    task automatic release_valid();
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < max), 32'd1);
    endtask

    // UART receiver: samples mid-bit on falling edges.
    initial begin : monitor
        int         mcnt;
        bit         mact;
        logic [7:0] msh;
        mact = 0;
        mcnt = 0;
        msh  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mact = 0;
            end else if (!mact) begin
                if (o_tx == 1'b0) begin
                    mact = 1;
                    mcnt = 0;
                end
            end else begin
                mcnt++;
                if (mcnt == 2) chk("start_bit", 32'(o_tx), 32'd0);
                if (mcnt >= 6 && mcnt <= 34 && ((mcnt - 6) % 4) == 0) msh = {o_tx, msh[7:1]};
                if (mcnt == 38) begin
                    chk("stop_bit", 32'(o_tx), 32'd1);
                    chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) chk("pkt_byte", 32'(msh), 32'(exp_q.pop_front()));
                    mact = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #(100000 * 10);
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int p0, n;
        reset_n = 1'b0;
        i_valid = 1'b0;
        i_alpha = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(o_tx), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_bad", 32'(o_bad_char), 32'd0);
        @(negedge clk) reset_n = 1'b1;

        // 'a': latency, duration, bytes AA 61 01 CA
        push(8'h61, 1);
        release_valid();
        n = 0;
        while (o_tx !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        chk("start_latency", 32'(cyc - pcyc), 32'd2);
        n = 0;
        while (o_busy && n < 400) begin @(negedge clk); n++; end
        chk("pkt_duration", 32'(cyc - pcyc), 32'd162);
        chk("a_ovf", 32'(o_overflow), 32'd0);
        chk("a_bad", 32'(o_bad_char), 32'd0);
        wait_idle(50);

        // 'z' -> AA 7A 35 E5
        push(8'h7A, 1);
        release_valid();
        wait_idle(400);

        // out-of-range -> AA 41 00 EB, bad_char sticky
        push(8'h41, 1);
        release_valid();
        wait_idle(400);
        chk("bad_set", 32'(o_bad_char), 32'd1);

        // reset mid-DATA of byte 2 ('c', dots 0x09, bit2 = 0 at push+96)
        push(8'h63, 1);
        release_valid();
        p0 = pcyc;
        while (cyc < p0 + 96) @(negedge clk);
        chk("mid_tx_low", 32'(o_tx), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(o_tx), 32'd1);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_bad", 32'(o_bad_char), 32'd0);
        exp_q.delete();
        // strobe present on the very first edge after release
        @(negedge clk);
        reset_n = 1'b1;
        i_valid = 1'b1;
        i_alpha = 8'h64;
        pcyc    = cyc + 1;
        exp_push(8'h64);
        release_valid();
        wait_idle(400);

        // ten consecutive strobes: 9 sent, 10th dropped
        for (int i = 0; i < 10; i++) push(8'h61 + 8'(i), i < 9);
        release_valid();
        chk("ovf_set", 32'(o_overflow), 32'd1);
        wait_idle(3000);
        chk("ovf_sticky", 32'(o_overflow), 32'd1);

        @(negedge clk) reset_n = 1'b0;
        @(negedge clk);
        chk("rst_ovf_clr", 32'(o_overflow), 32'd0);
        reset_n = 1'b1;

        // fill FIFO, then push on the LOAD (pop) cycle while full
        push(8'h61, 1);
        p0 = pcyc;
        for (int i = 1; i < 9; i++) push(8'h61 + 8'(i), 1);
        release_valid();
        while (cyc < p0 + 161) @(negedge clk);
        push(8'h6A, 1);
        release_valid();
        chk("full_pop_ovf", 32'(o_overflow), 32'd0);
        wait_idle(3000);
        chk("full_pop_ovf_end", 32'(o_overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
